// File: rtl/spart_rx_param.sv
// SPART RX channel: 16x oversampled serial receiver with error-flagged FIFO.
// Optional parity support is compiled in with `define SPART_RX_PARITY_EN.
module spart_rx_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  divisor,
    input  logic [1:0]        parity_mode,
    input  logic              rxd,
    input  logic              rd_en,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_perr,
    output logic              rd_ferr,
    output logic              rx_empty,
    output logic              rx_full,
    output logic              overrun,
    output logic              busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SPART_RX_PARITY_EN
    localparam int EW = DATA_W + 2;
`else
    localparam int EW = DATA_W + 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
`ifdef SPART_RX_PARITY_EN
        , S_PAR
`endif
    } state_t;

    logic              rx_s1, rx_s;
    logic [DIV_W-1:0]  div_m1, tcnt;
    logic              armed, tick, samp;
    state_t            state, state_n;
    logic [3:0]        scn, bcnt;
    logic [DATA_W-1:0] sh;
    logic              push, full, empty, pop, wr;
    logic [AW:0]       wp, rp;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [EW-1:0]     head, entry;
    logic              ovr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s  <= rx_s1;
        end
    end

    // First cycle after reset loads the divisor; afterwards free-running.
    assign div_m1 = (divisor < DIV_W'(2)) ? DIV_W'(1) : divisor - DIV_W'(1);
    assign tick   = armed && (tcnt == '0);
    assign samp   = tick && (scn == 4'd15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt  <= '0;
            armed <= 1'b0;
        end else if (!armed || tcnt == '0) begin
            tcnt  <= div_m1;
            armed <= 1'b1;
        end else begin
            tcnt <= tcnt - DIV_W'(1);
        end
    end

`ifdef SPART_RX_PARITY_EN
    logic [1:0] pmode;
    logic       perr;
    logic       par_on;
    assign par_on = (pmode == 2'd1) || (pmode == 2'd2);
`endif

    always_comb begin
        state_n = state;
        push    = 1'b0;
        case (state)
            S_IDLE:  if (!rx_s) state_n = S_START;
            S_START: if (tick && scn == 4'd7)
                         state_n = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (samp && bcnt == 4'(DATA_W - 1)) begin
`ifdef SPART_RX_PARITY_EN
                         state_n = par_on ? S_PAR : S_STOP;
`else
                         state_n = S_STOP;
`endif
                     end
`ifdef SPART_RX_PARITY_EN
            S_PAR:   if (samp) state_n = S_STOP;
`endif
            S_STOP:  if (samp) begin
                         push    = 1'b1;
                         state_n = rx_s ? S_IDLE : S_BRK;
                     end
            S_BRK:   if (rx_s) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            scn   <= '0;
        end else begin
            state <= state_n;
            if (state_n != state) scn <= '0;
            else if (tick)        scn <= scn + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh   <= '0;
            bcnt <= '0;
        end else begin
            if (state == S_START) bcnt <= '0;
            if (state == S_DATA && samp) begin
                sh   <= {rx_s, sh[DATA_W-1:1]};
                bcnt <= bcnt + 4'd1;
            end
        end
    end

`ifdef SPART_RX_PARITY_EN
    // Mode is latched at frame start so a mid-frame change cannot corrupt it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmode <= '0;
            perr  <= 1'b0;
        end else begin
            if (state == S_IDLE && state_n == S_START) begin
                pmode <= parity_mode;
                perr  <= 1'b0;
            end
            if (state == S_PAR && samp)
                perr <= (^sh) ^ rx_s ^ (pmode == 2'd2);
        end
    end
    assign entry = {sh, perr, ~rx_s};
`else
    logic unused_pm;
    assign unused_pm = ^parity_mode;
    assign entry     = {sh, ~rx_s};
`endif

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop   = rd_en && !empty;
    assign wr    = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wp[AW-1:0]] <= entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            ovr <= 1'b0;
        end else begin
            if (wr)  wp <= wp + (AW+1)'(1);
            if (pop) rp <= rp + (AW+1)'(1);
            if (push && full && !pop) ovr <= 1'b1;
            else if (clr_ovr)         ovr <= 1'b0;
        end
    end

    assign head     = mem[rp[AW-1:0]];
    assign rd_data  = empty ? '0 : head[EW-1 -: DATA_W];
    assign rd_ferr  = !empty && head[0];
`ifdef SPART_RX_PARITY_EN
    assign rd_perr  = !empty && head[1];
`else
    assign rd_perr  = 1'b0;
`endif
    assign rx_empty = empty;
    assign rx_full  = full;
    assign overrun  = ovr;
    assign busy     = (state != S_IDLE);

endmodule

// File: doc/spart_rx_param.md
# spart_rx_param

Parametrised SPART receive channel: 16x-oversampled asynchronous serial receiver with a runtime-programmable baud divisor and optional parity checking. Received frames land in a show-ahead FIFO together with per-frame error flags. It is the next-generation RX path behind the board GPIO serial pin, generalised in data width, FIFO depth and frame format, and it adds error reporting and overrun detection.

## Interface
Parameters:
- DATA_W, 8: data bits per frame, legal range 5..9.
- FIFO_DEPTH, 8: RX FIFO entries, power of two, at least 2.
- DIV_W, 16: width of the divisor input.

Ports:
- clk  in  1  system clock (50 MHz on board).
- rst  in  1  asynchronous, active-high reset.
- divisor  in  DIV_W  clk cycles per oversample tick; values below 2 are treated as 2.
- parity_mode  in  2  0 none, 1 even, 2 odd, 3 reserved (treated as none).
- rxd  in  1  serial input, idle high.
- rd_en  in  1  pop the FIFO head; ignored when rx_empty.
- clr_ovr  in  1  clears the overrun flag.
- rd_data  out  DATA_W  FIFO head data; valid while !rx_empty.
- rd_perr  out  1  parity error flag of the head frame.
- rd_ferr  out  1  framing error flag of the head frame.
- rx_empty  out  1  FIFO empty.
- rx_full  out  1  FIFO full.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- busy  out  1  FSM not in IDLE.

## Operation
- rxd passes through a 2-flop synchronizer; both flops reset to 1. All uses of rxd below refer to the synchronized value.
- Tick generator: a down-counter loads divisor-1, emits a one-cycle tick when it reaches 0, then reloads.
  - A new divisor value takes effect at the next reload.
  - The counter free-runs in all states.
  - 16 ticks make one bit period (divisor 324 gives 5184 clk per bit, 9600 baud at 50 MHz).
- A 4-bit sample counter scn advances on each tick. It is cleared on every state entry.
- FSM states:
  - IDLE: on rxd==0, go to START.
  - START: at scn==7 (mid start bit), sample rxd. If 1 (glitch), return to IDLE. If 0, clear scn and go to DATA.
  - DATA: on every 16th tick, shift rxd into the shift register, LSB first. After DATA_W bits, go to PARITY if parity is active, otherwise STOP.
  - PARITY: on the 16th tick, sample the parity bit and compute perr.
    - Even mode: perr = XOR of data and parity bit is 1.
    - Odd mode: perr = XOR of data and parity bit is 0.
  - STOP: on the 16th tick (mid stop bit), sample rxd; ferr = (rxd==0). Push {data, perr, ferr} and go to IDLE. If ferr, go to BRK instead.
  - BRK: wait for rxd==1, then go to IDLE. This prevents a held-low line from retriggering.
- Push rules:
  - A push while full with rd_en low drops the frame and sets overrun.
  - A push while full with rd_en high: the pop and the push both succeed.
  - A simultaneous push and pop when empty is impossible, because rd_en is ignored when empty.
- overrun clears on clr_ovr. If clr_ovr and a new overrun occur in the same cycle, the set wins.
- parity_mode is sampled when START is entered and held for the whole frame.

## Timing
- Reset values:
  - FSM in IDLE, FIFO empty.
  - rx_empty=1, rx_full=0, overrun=0, busy=0.
  - rd_data=0, rd_perr=0, rd_ferr=0.
  - Tick counter loaded with divisor-1.
- Latency from the stop-sample tick cycle to rx_empty falling is 1 clk, with rd_data valid in that same cycle.
- rd_en in cycle N: the next entry, or rx_empty=1, is visible in cycle N+1. rx_full falls in N+1.
- Start detection to START entry is 1 clk after the synchronized edge; the synchronizer adds 2 clk.
- The mid-bit sample point falls 7–8 ticks after the start edge, with ±1 tick jitter from the free-running tick counter.
- Reset asserted mid-frame discards the frame immediately; no partial push occurs.

## Configuration
- SPART_RX_PARITY_EN defined:
  - The PARITY state and parity logic are present.
  - parity_mode is honoured.
- SPART_RX_PARITY_EN undefined:
  - The PARITY state is absent and parity_mode is ignored.
  - Frames are always data followed by stop.
  - rd_perr is tied 0 and the FIFO does not store a parity bit.

## Test plan
- Reset, divisor=324, parity none, send 0xA5 (start, bits LSB first, stop) at 5184 clk/bit -> rx_empty falls about 9.5 bit times after the start edge; rd_data=0xA5, rd_perr=0, rd_ferr=0.
- Even parity, send 0x3C with parity bit 1 -> rd_perr=1. Resend with parity bit 0 -> rd_perr=0. Repeat in odd mode and expect the inverse results. (Run only with SPART_RX_PARITY_EN defined.)
- Send 0x55 with the stop bit held 0 for 3 bit times, then idle, then send 0x12 -> first entry has rd_ferr=1; the second entry is 0x12 with ferr=0; no spurious frames.
- 4-bit-tick low glitch on rxd -> busy rises, returns to IDLE at scn 7, FIFO stays empty.
- FIFO_DEPTH=4:
  - Send 5 frames with no reads -> rx_full=1, overrun=1, FIFO holds the first 4 frames.
  - Pulse clr_ovr -> overrun=0.
  - Pop 4 -> data returned in order, rx_empty=1.
- Change divisor 324 to 27 between frames, send 0xFF at 432 clk/bit -> rd_data=0xFF. Assert rst mid-frame -> all outputs return to their reset values and no push occurs.
